codec_config_seq: RTL and testbench

CODEC_CONFIG_SEQ -- requirements
Module: codec_config_seq

---
 rtl/codec_config_seq_pkg.sv | 47 ++++
 rtl/codec_config_seq_rom.sv | 13 +
 rtl/codec_config_seq.sv | 109 ++++++++++
 tb/tb_codec_config_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/codec_config_seq_pkg.sv
// Shared I2C constants: transmitter states, config sequencer states and the
// WM8731 power-up register table.
package codec_config_seq_pkg;

    localparam int CFG_IDX_W  = 4;
    localparam int CFG_WORD_W = 16;
    localparam int WM8731_NUM_WORDS = 11;

    // I2C byte transmitter states
    localparam logic [3:0] TX_IDLE  = 4'd0;
    localparam logic [3:0] TX_START = 4'd1;
    localparam logic [3:0] TX_ADDR  = 4'd2;
    localparam logic [3:0] TX_ACK0  = 4'd3;
    localparam logic [3:0] TX_BYTE1 = 4'd4;
    localparam logic [3:0] TX_ACK1  = 4'd5;
    localparam logic [3:0] TX_BYTE2 = 4'd6;
    localparam logic [3:0] TX_ACK2  = 4'd7;
    localparam logic [3:0] TX_STOP  = 4'd8;

    // Configuration sequencer states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_ERR   = 3'd6;

    // Words are {7-bit register address, 9-bit value}; out-of-range reads give 0.
    function automatic logic [CFG_WORD_W-1:0] wm8731_word(input logic [CFG_IDX_W-1:0] idx);
        case (idx)
            4'd0:    wm8731_word = 16'h1E00;
            4'd1:    wm8731_word = 16'h0017;
            4'd2:    wm8731_word = 16'h0217;
            4'd3:    wm8731_word = 16'h0479;
            4'd4:    wm8731_word = 16'h0679;
            4'd5:    wm8731_word = 16'h0812;
            4'd6:    wm8731_word = 16'h0A06;
            4'd7:    wm8731_word = 16'h0C00;
            4'd8:    wm8731_word = 16'h0E01;
            4'd9:    wm8731_word = 16'h1000;
            4'd10:   wm8731_word = 16'h1201;
            default: wm8731_word = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/codec_config_seq_rom.sv
// Combinational WM8731 configuration word ROM.
module codec_cfg_rom
    import codec_config_seq_pkg::*;
(
    input  logic [CFG_IDX_W-1:0]  index,
    output logic [CFG_WORD_W-1:0] word
);

    always_comb begin
        word = wm8731_word(index);
    end

endmodule

// File: rtl/codec_config_seq.sv
// Issues the WM8731 register table over I2C, one word per transaction,
// with bounded NACK retries and a fixed bus-free gap between transactions.
module codec_config_seq
    import codec_config_seq_pkg::*;
#(
    parameter int NUM_REGS   = 11,
    parameter int MAX_RETRY  = 3,
    parameter int GAP_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  go,
    input  logic                  i2c_done,
    input  logic                  i2c_nack,
    output logic                  i2c_start,
    output logic [CFG_WORD_W-1:0] i2c_data,
    output logic [CFG_IDX_W-1:0]  cfg_index,
    output logic                  cfg_busy,
    output logic                  cfg_done,
    output logic                  cfg_err
);

    localparam int RTY_W = (MAX_RETRY  > 0) ? $clog2(MAX_RETRY + 1)  : 1;
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    logic [2:0]            state;
    logic [RTY_W-1:0]      retry_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic                  go_q;
    logic                  go_armed;
    logic                  go_rise;
    logic [CFG_WORD_W-1:0] rom_word;

    codec_cfg_rom u_rom (
        .index (cfg_index),
        .word  (rom_word)
    );

    // go must be seen low after reset before an edge counts, so a go
    // already high at reset release does not start a sequence.
    assign go_rise   = go & ~go_q & go_armed;
    assign i2c_start = (state == ST_ISSUE);
    assign cfg_busy  = (state == ST_LOAD) || (state == ST_ISSUE) ||
                       (state == ST_WAIT) || (state == ST_GAP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            i2c_data  <= '0;
            cfg_index <= '0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            retry_cnt <= '0;
            gap_cnt   <= '0;
            go_q      <= 1'b0;
            go_armed  <= 1'b0;
        end else begin
            go_q     <= go;
            go_armed <= go_armed | ~go;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (go_rise) begin
                        state     <= ST_LOAD;
                        cfg_index <= '0;
                        retry_cnt <= '0;
                        gap_cnt   <= '0;
                        cfg_done  <= 1'b0;
                        cfg_err   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    i2c_data <= rom_word;
                    state    <= ST_ISSUE;
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (i2c_done) begin
                        if (!i2c_nack) begin
                            cfg_index <= cfg_index + 1'b1;
                            retry_cnt <= '0;
                            state     <= ST_GAP;
                        end else if (retry_cnt == RTY_W'(MAX_RETRY)) begin
                            cfg_err <= 1'b1;
                            state   <= ST_ERR;
                        end else begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        gap_cnt <= '0;
                        if (cfg_index == CFG_IDX_W'(NUM_REGS)) begin
                            cfg_done <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_codec_config_seq.sv
// Directed bench for codec_config_seq with a simple I2C transmitter model.
module tb_codec_config_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        go;
    logic        i2c_done;
    logic        i2c_nack;
    logic        i2c_start;
    logic [15:0] i2c_data;
    logic [3:0]  cfg_index;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_err;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    logic [15:0] rom_ref [0:10] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                                    16'h0812, 16'h0A06, 16'h0C00, 16'h0E01, 16'h1000,
                                    16'h1201};

    typedef struct {
        string name;
        int    nack_idx;
        int    nack_cnt;
        bit    toggle_go;
        bit    spurious;
        int    exp_starts;
        bit    exp_done;
        bit    exp_err;
    } vec_t;

    vec_t vecs [6];

    codec_config_seq #(.NUM_REGS(11), .MAX_RETRY(3), .GAP_CYCLES(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .go        (go),
        .i2c_done  (i2c_done),
        .i2c_nack  (i2c_nack),
        .i2c_start (i2c_start),
        .i2c_data  (i2c_data),
        .cfg_index (cfg_index),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " i2c_start"}, 32'(i2c_start), 0);
        chk({tag, " i2c_data"},  32'(i2c_data),  0);
        chk({tag, " cfg_index"}, 32'(cfg_index), 0);
        chk({tag, " cfg_busy"},  32'(cfg_busy),  0);
        chk({tag, " cfg_done"},  32'(cfg_done),  0);
        chk({tag, " cfg_err"},   32'(cfg_err),   0);
    endtask

    task automatic wait_start(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (i2c_start) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // Runs one sequence: starts it with a fresh go edge, ACK/NACKs according
    // to v, and checks every issued word, the gap spacing and the final flags.
    // Returns early (left in WAIT) once index abort_idx has been issued.
    task automatic run_seq(input vec_t v, input int abort_idx);
        int          exp_q[$];
        int          k;
        int          nacked;
        int          last_done;
        int          idx;
        bit          seen;
        bit          nack;
        logic [15:0] w;
        for (int i = 0; i < 11; i++) begin
            if (i == v.nack_idx) begin
                int n;
                n = (v.nack_cnt >= 4) ? 4 : v.nack_cnt + 1;
                for (int j = 0; j < n; j++) exp_q.push_back(i);
                if (v.nack_cnt >= 4) break;
            end else begin
                exp_q.push_back(i);
            end
        end
        @(negedge clk); go = 1'b0;
        @(negedge clk); go = 1'b0;
        @(negedge clk); go = 1'b1;
        k = 0; nacked = 0; last_done = -1;
        forever begin
            wait_start(60, seen);
            if (!seen) break;
            w   = i2c_data;
            idx = int'(cfg_index);
            if (k == 0) begin
                chk({v.name, " done cleared"}, 32'(cfg_done), 0);
                chk({v.name, " err cleared"},  32'(cfg_err),  0);
            end
            if (k < exp_q.size()) begin
                chk($sformatf("%s index[%0d]", v.name, k), idx, exp_q[k]);
                chk($sformatf("%s word[%0d]", v.name, k), 32'(w), 32'(rom_ref[exp_q[k]]));
            end
            if (last_done >= 0) chk($sformatf("%s gap[%0d]", v.name, k), cyc - last_done, 6);
            k++;
            if (idx == abort_idx) return;
            @(negedge clk);
            chk($sformatf("%s start width[%0d]", v.name, k), 32'(i2c_start), 0);
            if (v.toggle_go) go = 1'b0;
            @(negedge clk);
            if (v.toggle_go) go = 1'b1;
            @(negedge clk);
            nack = (idx == v.nack_idx) && (nacked < v.nack_cnt);
            if (nack) nacked++;
            i2c_done  = 1'b1;
            i2c_nack  = nack;
            last_done = cyc;
            @(negedge clk);
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
            chk($sformatf("%s data hold[%0d]", v.name, k), 32'(i2c_data), 32'(w));
            if (v.spurious) begin
                @(negedge clk);
                i2c_done = 1'b1;
                i2c_nack = 1'($urandom_range(0, 1));
                @(negedge clk);
                i2c_done = 1'b0;
                i2c_nack = 1'b0;
            end
        end
        chk({v.name, " starts"},   k, v.exp_starts);
        chk({v.name, " cfg_done"}, 32'(cfg_done), 32'(v.exp_done));
        chk({v.name, " cfg_err"},  32'(cfg_err),  32'(v.exp_err));
        chk({v.name, " cfg_busy"}, 32'(cfg_busy), 0);
    endtask

    initial begin
        bit seen;
        vecs[0] = '{"clean",        15, 0,  1'b0, 1'b0, 11, 1'b1, 1'b0};
        vecs[1] = '{"nack1_idx3",   3,  1,  1'b0, 1'b0, 12, 1'b1, 1'b0};
        vecs[2] = '{"nackall_idx5", 5,  99, 1'b0, 1'b0, 9,  1'b0, 1'b1};
        vecs[3] = '{"nack3_idx0",   0,  3,  1'b0, 1'b0, 14, 1'b1, 1'b0};
        vecs[4] = '{"noise_idx10",  10, 1,  1'b1, 1'b1, 12, 1'b1, 1'b0};
        vecs[5] = '{"nack4_idx10",  10, 4,  1'b0, 1'b0, 14, 1'b0, 1'b1};

        reset_n  = 1'b0;
        go       = 1'b1;
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        reset_n = 1'b1;
        wait_start(15, seen);
        chk("go held through reset", 32'(seen), 0);

        for (int t = 0; t < 6; t++) run_seq(vecs[t], 15);

        // Reset while index 6 is in flight, with go still high.
        run_seq(vecs[0], 6);
        @(negedge clk);
        chk("in WAIT before reset", 32'(cfg_busy), 1);
        reset_n = 1'b0;
        #1;
        check_reset("abort");
        @(negedge clk);
        reset_n = 1'b1;
        wait_start(20, seen);
        chk("no start after abort", 32'(seen), 0);
        go = 1'b0;
        @(negedge clk);
        go = 1'b1;
        wait_start(20, seen);
        chk("restart seen", 32'(seen), 1);
        chk("restart index", 32'(cfg_index), 0);
        chk("restart word",  32'(i2c_data), 32'h1E00);

        reset_n = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
